pixel_serializer: RTL and testbench

Downstream neighbour of the iteration-to-colour LUT stage: accepts one batch of NUM_ENGINES 24-bit RGB values per handshake and emits them one pixel per cycle on a ready/valid video stream. The stream carries start-of-frame and end-of-line markers and raster coordinates. It sits between the colour LUT and the frame output interface, so the engine array only has to advance once per emitted batch.

---
 rtl/mandel_pkg.sv | 24 ++
 rtl/pixel_xy_counter.sv | 53 +++++
 rtl/pixel_serializer.sv | 167 ++++++++++++++++
 tb/tb_pixel_serializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// ---------------------------------------------------------------------------
// mandel_pkg
// Shared constants and types for the frame-side stages of the Mandelbrot
// renderer: pixel size, engine count, default frame geometry, the RGB pixel
// type and the pixel serializer state encoding.
// ---------------------------------------------------------------------------
package mandel_pkg;

  localparam int RBG_SIZE     = 24;
  localparam int NUM_ENGINES  = 12;
  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;

  // Width of a lane index into one engine batch.
  localparam int IDX_W = $clog2(NUM_ENGINES);

  typedef logic [RBG_SIZE-1:0] rgb_t;

  typedef enum logic {
    IDLE,
    EMIT
  } ser_state_t;

endpackage

// File: rtl/pixel_xy_counter.sv
// ---------------------------------------------------------------------------
// pixel_xy_counter
// Raster x/y position counter. Advances one pixel per 'advance' pulse,
// wrapping x at FRAME_WIDTH-1 (and bumping y), and y at FRAME_HEIGHT-1.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (position -> 0,0)
//   advance  in   step to the next raster position
//   x        out  current column
//   y        out  current row
//   sof      out  position is (0,0)
//   eol      out  position is the last column of a line
//   last     out  position is the last pixel of the frame
// ---------------------------------------------------------------------------
module pixel_xy_counter #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               sof,
  output logic               eol,
  output logic               last
);

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(FRAME_HEIGHT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (eol) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign sof  = (x == '0) && (y == '0);
  assign eol  = (x == X_LAST);
  assign last = eol && (y == Y_LAST);

endmodule

// File: rtl/pixel_serializer.sv
// ---------------------------------------------------------------------------
// pixel_serializer
// Takes one batch of NUM_ENGINES RGB pixels per input handshake and plays it
// out one pixel per cycle on a ready/valid video stream with raster
// coordinates, start-of-frame / end-of-line markers and a frame_done pulse.
// The next batch can be loaded on the handshake of the current batch's last
// lane, so back-to-back batches stream without a bubble.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_rgb       in   batch of NUM_ENGINES pixels, lane 0 = leftmost
//   in_valid     in   batch valid
//   in_ready     out  batch accepted when in_valid && in_ready
//                     (combinational from out_ready)
//   out_data     out  current pixel
//   out_valid    out  pixel valid
//   out_ready    in   sink accepts when out_valid && out_ready
//   out_sof      out  pixel is (0,0)
//   out_eol      out  pixel is the last column of its line
//   out_x/out_y  out  raster position of out_data
//   frame_done   out  one-cycle pulse after the last pixel of a frame
//   stall_cycles out  (only with PIXEL_SERIALIZER_PERF_EN defined) saturating
//                     count of stalled output cycles, cleared per frame
//
// Optional feature macro: PIXEL_SERIALIZER_PERF_EN
// ---------------------------------------------------------------------------
module pixel_serializer #(
  parameter int FRAME_WIDTH  = mandel_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = mandel_pkg::FRAME_HEIGHT,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  mandel_pkg::rgb_t   in_rgb [mandel_pkg::NUM_ENGINES],
  input  logic               in_valid,
  output logic               in_ready,
  output mandel_pkg::rgb_t   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eol,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y,
  output logic               frame_done
`ifdef PIXEL_SERIALIZER_PERF_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  import mandel_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENGINES - 1);

  ser_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  rgb_t             batch [NUM_ENGINES];

  logic last_lane;
  logic hs_in;
  logic hs_out;
  logic pix_sof;
  logic pix_eol;
  logic pix_last;

  assign last_lane = (idx == LAST_IDX);
  assign out_valid = (state == EMIT);
  assign hs_out    = out_valid && out_ready;

  // A new batch fits when the buffer is empty, or when the final lane is
  // leaving this very cycle. Gated by rst_n so nothing is accepted in reset.
  assign in_ready = rst_n && ((state == IDLE) || (last_lane && out_ready));
  assign hs_in    = in_valid && in_ready;

  // --- Control state register ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (hs_in) begin
          state_nxt = EMIT;
          idx_nxt   = '0;
        end
      end
      EMIT: begin
        if (hs_out) begin
          if (!last_lane) begin
            idx_nxt = idx + 1'b1;
          end else if (hs_in) begin
            idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // --- Batch buffer (data only, no reset needed) ---
  always_ff @(posedge clk) begin
    if (hs_in) begin
      batch <= in_rgb;
    end
  end

  // Pixel data and markers read as zero whenever nothing is being offered,
  // which also yields the zero values seen during and after reset.
  assign out_data = out_valid ? batch[idx] : '0;
  assign out_sof  = out_valid && pix_sof;
  assign out_eol  = out_valid && pix_eol;

  pixel_xy_counter #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .X_WIDTH      (X_WIDTH),
    .Y_WIDTH      (Y_WIDTH)
  ) u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (hs_out),
    .x       (out_x),
    .y       (out_y),
    .sof     (pix_sof),
    .eol     (pix_eol),
    .last    (pix_last)
  );

  // --- Frame completion pulse ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs_out && pix_last;
    end
  end

`ifdef PIXEL_SERIALIZER_PERF_EN
  // --- Stall counter, restarted for every frame ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (frame_done) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
module tb_pixel_serializer;
  import mandel_pkg::*;

  localparam int W  = 40;
  localparam int H  = 5;
  localparam int F  = W * H;
  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   in_rgb [NUM_ENGINES];
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          frame_done;
`ifdef PIXEL_SERIALIZER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  pixel_serializer #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .X_WIDTH      (XW),
    .Y_WIDTH      (YW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_rgb     (in_rgb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
`ifdef PIXEL_SERIALIZER_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Reference model: queue of pixels still owed to the sink, plus the
  // running pixel index within the frame (coordinates follow from it).
  logic [23:0] q [$];
  int          n_pix;
  bit          fd_exp;
  logic [31:0] stall_exp;
  int          accepted;
  int          pops;
  int          frames;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_batch();
    for (int i = 0; i < NUM_ENGINES; i++) in_rgb[i] = 24'($urandom);
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step(input bit iv, input bit ordy);
    bit exp_valid, exp_ready, hin, hout;
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    if (exp_valid) begin
      chk("out_data", 32'(out_data), 32'(q[0]));
      chk("out_x", 32'(out_x), 32'(n_pix % W));
      chk("out_y", 32'(out_y), 32'(n_pix / W));
      chk("out_sof", 32'(out_sof), 32'(n_pix == 0));
      chk("out_eol", 32'(out_eol), 32'((n_pix % W) == W - 1));
    end
`ifdef PIXEL_SERIALIZER_PERF_EN
    chk("stall_cycles", stall_cycles, stall_exp);
`endif
    hin  = iv && exp_ready;
    hout = exp_valid && ordy;
    if (fd_exp) stall_exp = '0;
    else if (exp_valid && !ordy && stall_exp != '1) stall_exp = stall_exp + 1;
    fd_exp = hout && (n_pix == F - 1);
    if (fd_exp) frames++;
    if (hout) begin
      void'(q.pop_front());
      n_pix = (n_pix + 1) % F;
      pops++;
    end
    if (hin) begin
      for (int i = 0; i < NUM_ENGINES; i++) q.push_back(in_rgb[i]);
      accepted++;
    end
    @(posedge clk);
    #1;
    if (hin) new_batch();
  endtask

  // Asynchronous reset applied just after a clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    q.delete();
    n_pix     = 0;
    fd_exp    = 1'b0;
    stall_exp = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int p0, a0, budget;
    n_cmp = 0; n_err = 0; accepted = 0; pops = 0; frames = 0;
    n_pix = 0; fd_exp = 1'b0; stall_exp = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NUM_ENGINES; i++) in_rgb[i] = '0;

    // Reset state
    #2;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd0);
    chk("init_out_data", 32'(out_data), 32'd0);
    chk("init_out_sof", 32'(out_sof), 32'd0);
    chk("init_out_eol", 32'(out_eol), 32'd0);
    chk("init_frame_done", 32'(frame_done), 32'd0);
    chk("init_out_x", 32'(out_x), 32'd0);
    chk("init_out_y", 32'(out_y), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single batch, lane i = i<<4, sink always ready
    for (int i = 0; i < NUM_ENGINES; i++) in_rgb[i] = 24'(i << 4);
    step(1'b1, 1'b1);
    for (int i = 0; i < NUM_ENGINES + 2; i++) step(1'b0, 1'b1);
    chk("single_pops", 32'(pops), 32'd12);

    // Two batches back-to-back with in_valid held
    p0 = pops; a0 = accepted; budget = 0;
    while (pops < p0 + 2 * NUM_ENGINES && budget < 100) begin
      step(accepted < a0 + 2, 1'b1);
      budget++;
    end
    chk("b2b_pops", 32'(pops - p0), 32'(2 * NUM_ENGINES));
    chk("b2b_no_gap", 32'(budget <= 2 * NUM_ENGINES + 1), 32'd1);
    step(1'b0, 1'b1);

    // Random traffic with backpressure
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);

    // Reset after lane 5 of a batch
    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      step(1'b0, 1'b1);
      budget++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
    step(1'b1, 1'b1);
    p0 = pops; budget = 0;
    while (pops < p0 + 6 && budget < 100) begin
      step(1'b0, $urandom_range(0, 3) != 0);
      budget++;
    end
    chk("lane5_reached", 32'(pops - p0), 32'd6);
    do_reset();
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Two full frames with occasional stalls and input gaps
    frames = 0; budget = 0;
    while (frames < 2 && budget < 3 * F + 400) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      budget++;
    end
    chk("frames_done", 32'(frames), 32'd2);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);

`ifdef PIXEL_SERIALIZER_PERF_EN
    // Seven stalled cycles right after reset
    do_reset();
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    @(negedge clk);
    chk("stall_seven", stall_cycles, 32'd7);
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
